// File: rtl/ctrl_pkg.sv
// Shared opcode/funct encodings, ALU and memory-size codes, and the ID/EX
// control bundle for the pipeline control unit.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_LWU   = 6'b100111;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mem_size_e;

  typedef struct packed {
    logic      reg_dst;
    logic      branch;
    logic      bne;
    logic      mem_read;
    logic      mem_to_reg;
    logic      mem_write;
    logic      alu_src;
    logic      reg_write;
    logic      jump;
    logic      shift;
    logic      md_start;
    alu_op_e   alu_op;
    mem_size_e mem_size;
    logic      mem_unsigned;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Loads and stores encode their access width in op[1:0]: 00 byte, 01 half, 11 word.
  function automatic mem_size_e size_of(input logic [5:0] op);
    case (op[1:0])
      2'b00:   return SIZE_BYTE;
      2'b01:   return SIZE_HALF;
      default: return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational main-control decoder: opcode/funct to control bundle,
// plus source-usage and illegal-instruction flags.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       uses_rt,
  output logic       mf_op,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    uses_rt = 1'b0;
    mf_op   = 1'b0;
    illegal = 1'b0;

    case (op)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
        uses_rt        = 1'b1;
        case (funct)
          F_SLL, F_SRL, F_SRA: ctrl.shift = 1'b1;
          F_MFHI, F_MFLO:      mf_op = 1'b1;
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            ctrl.md_start  = 1'b1;
            ctrl.reg_write = 1'b0;
          end
          F_SLLV, F_SRLV, F_SRAV, F_ADD, F_ADDU, F_SUB, F_SUBU,
          F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: ;
          default: illegal = 1'b1;
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
        ctrl.mem_read     = 1'b1;
        ctrl.mem_to_reg   = 1'b1;
        ctrl.alu_src      = 1'b1;
        ctrl.reg_write    = 1'b1;
        ctrl.alu_op       = ALU_ADD;
        ctrl.mem_size     = size_of(op);
        ctrl.mem_unsigned = op[2];
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.mem_size  = size_of(op);
        uses_rt        = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch = 1'b1;
        ctrl.bne    = op[0];
        ctrl.alu_op = ALU_SUB;
        uses_rt     = 1'b1;
      end
      OP_J: ctrl.jump = 1'b1;
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      ctrl    = CTRL_BUBBLE;
      uses_rt = 1'b0;
      mf_op   = 1'b0;
    end
  end

endmodule

// File: rtl/control_pipe_unit.sv
// Registered main control and hazard unit between IF/ID and ID/EX: load-use
// and MULT/DIV interlocks, branch/jump flushes, and the ID/EX control register.
module control_pipe_unit #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned RA_W   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [5:0]      id_op,
  input  logic [5:0]      id_funct,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            branch_taken,
  output logic            ex_reg_dst,
  output logic            ex_branch,
  output logic            ex_bne,
  output logic            ex_mem_read,
  output logic            ex_mem_to_reg,
  output logic            ex_mem_write,
  output logic            ex_alu_src,
  output logic            ex_reg_write,
  output logic            ex_jump,
  output logic            ex_shift,
  output logic            ex_md_start,
  output logic [1:0]      ex_alu_op,
  output logic [1:0]      ex_mem_size,
  output logic            ex_mem_unsigned,
  output logic [RA_W-1:0] ex_rt,
  output logic            pc_write,
  output logic            if_id_write,
  output logic            if_flush,
  output logic            md_busy,
  output logic            illegal
);
  import ctrl_pkg::*;

  localparam int unsigned CW = (MD_LAT < 1) ? 1 : $clog2(MD_LAT + 1);

  ctrl_t           dec_ctrl;
  logic            dec_uses_rt;
  logic            dec_mf;
  logic            dec_illegal;

  ctrl_t           ex_ctrl;
  ctrl_t           nxt_ctrl;
  logic [RA_W-1:0] nxt_rt;
  logic            nxt_illegal;
  logic [CW-1:0]   md_cnt;
  logic            load_use;
  logic            md_hazard;

  ctrl_decode u_decode (
    .op      (id_op),
    .funct   (id_funct),
    .ctrl    (dec_ctrl),
    .uses_rt (dec_uses_rt),
    .mf_op   (dec_mf),
    .illegal (dec_illegal)
  );

  assign md_busy = (md_cnt != '0);

  assign load_use = ex_ctrl.mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (dec_uses_rt && (ex_rt == id_rt)));

  // The dependent op is released on the last busy cycle: it reaches EX
  // exactly as the counter hits zero, so HI/LO is ready when it is used.
  assign md_hazard = (md_cnt > CW'(1)) && (dec_mf || dec_ctrl.md_start);

  always_comb begin
    nxt_ctrl    = dec_ctrl;
    nxt_rt      = dec_illegal ? '0 : id_rt;
    nxt_illegal = dec_illegal;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_flush    = 1'b0;

    if (branch_taken) begin
      nxt_ctrl    = CTRL_BUBBLE;
      nxt_rt      = '0;
      nxt_illegal = 1'b0;
      if_flush    = 1'b1;
    end else if (!enable || md_hazard || load_use) begin
      nxt_ctrl    = CTRL_BUBBLE;
      nxt_rt      = '0;
      nxt_illegal = 1'b0;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (dec_ctrl.jump) begin
      if_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl <= CTRL_BUBBLE;
      ex_rt   <= '0;
      illegal <= 1'b0;
      md_cnt  <= '0;
    end else begin
      ex_ctrl <= nxt_ctrl;
      ex_rt   <= nxt_rt;
      illegal <= nxt_illegal;
      if (nxt_ctrl.md_start)
        md_cnt <= CW'(MD_LAT);
      else if (md_busy)
        md_cnt <= md_cnt - 1'b1;
    end
  end

  assign ex_reg_dst      = ex_ctrl.reg_dst;
  assign ex_branch       = ex_ctrl.branch;
  assign ex_bne          = ex_ctrl.bne;
  assign ex_mem_read     = ex_ctrl.mem_read;
  assign ex_mem_to_reg   = ex_ctrl.mem_to_reg;
  assign ex_mem_write    = ex_ctrl.mem_write;
  assign ex_alu_src      = ex_ctrl.alu_src;
  assign ex_reg_write    = ex_ctrl.reg_write;
  assign ex_jump         = ex_ctrl.jump;
  assign ex_shift        = ex_ctrl.shift;
  assign ex_md_start     = ex_ctrl.md_start;
  assign ex_alu_op       = ex_ctrl.alu_op;
  assign ex_mem_size     = ex_ctrl.mem_size;
  assign ex_mem_unsigned = ex_ctrl.mem_unsigned;

endmodule

// File: tb/tb_control_pipe_unit.sv
// Directed bench for control_pipe_unit: expected ID/EX contents are queued as
// each instruction is presented and checked one cycle later.
module tb_control_pipe_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [5:0] id_op, id_funct;
  logic [4:0] id_rs, id_rt;
  logic       branch_taken;
  logic       ex_reg_dst, ex_branch, ex_bne, ex_mem_read, ex_mem_to_reg, ex_mem_write;
  logic       ex_alu_src, ex_reg_write, ex_jump, ex_shift, ex_md_start, ex_mem_unsigned;
  logic [1:0] ex_alu_op, ex_mem_size;
  logic [4:0] ex_rt;
  logic       pc_write, if_id_write, if_flush, md_busy, illegal;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [15:0] ctl;
    logic [4:0]  rt;
    logic        ill;
    logic        busy;
  } exp_t;
  exp_t sbq[$];

  logic [15:0] obs;
  assign obs = {ex_reg_dst, ex_branch, ex_bne, ex_mem_read, ex_mem_to_reg, ex_mem_write,
                ex_alu_src, ex_reg_write, ex_jump, ex_shift, ex_md_start,
                ex_alu_op, ex_mem_size, ex_mem_unsigned};

  control_pipe_unit #(.MD_LAT(4), .RA_W(5)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .id_op(id_op), .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt),
    .branch_taken(branch_taken),
    .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch), .ex_bne(ex_bne),
    .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_jump(ex_jump),
    .ex_shift(ex_shift), .ex_md_start(ex_md_start), .ex_alu_op(ex_alu_op),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned), .ex_rt(ex_rt),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_flush(if_flush),
    .md_busy(md_busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic rd, br, bn, mr, m2r, mw, as, rw, j, sh, md,
                                     input logic [1:0] aop, msz, input logic mu);
    return {rd, br, bn, mr, m2r, mw, as, rw, j, sh, md, aop, msz, mu};
  endfunction

  // hz = {pc_write, if_id_write, if_flush} during the cycle the instruction sits in ID.
  task automatic step(input string tag, input logic [5:0] op, fn, input logic [4:0] rs, rt,
                      input logic bt, en, input logic [2:0] hz,
                      input logic [15:0] ectl, input logic [4:0] ert, input logic eill, ebusy);
    exp_t e;
    id_op = op; id_funct = fn; id_rs = rs; id_rt = rt;
    branch_taken = bt; enable = en;
    #2;
    tests++;
    assert ({pc_write, if_id_write, if_flush} === hz) else begin
      fails++;
      $error("FAIL %s hazard: got %b want %b", tag, {pc_write, if_id_write, if_flush}, hz);
    end
    sbq.push_back('{ectl, ert, eill, ebusy});
    @(posedge clk); #1;
    e = sbq.pop_front();
    tests++;
    assert (obs === e.ctl) else begin
      fails++; $error("FAIL %s ctrl: got %b want %b", tag, obs, e.ctl);
    end
    tests++;
    assert (ex_rt === e.rt) else begin
      fails++; $error("FAIL %s ex_rt: got %0d want %0d", tag, ex_rt, e.rt);
    end
    tests++;
    assert (illegal === e.ill) else begin
      fails++; $error("FAIL %s illegal: got %b want %b", tag, illegal, e.ill);
    end
    tests++;
    assert (md_busy === e.busy) else begin
      fails++; $error("FAIL %s md_busy: got %b want %b", tag, md_busy, e.busy);
    end
  endtask

  logic [15:0] e_bub, e_add, e_sll, e_lw, e_sw, e_addi, e_mult, e_mflo, e_bne, e_beq, e_j;

  initial begin
    e_bub  = '0;
    e_add  = mk(1,0,0,0,0,0,0,1,0,0,0, 2'b10, 2'b00, 0);
    e_sll  = mk(1,0,0,0,0,0,0,1,0,1,0, 2'b10, 2'b00, 0);
    e_lw   = mk(0,0,0,1,1,0,1,1,0,0,0, 2'b00, 2'b10, 0);
    e_sw   = mk(0,0,0,0,0,1,1,0,0,0,0, 2'b00, 2'b10, 0);
    e_addi = mk(0,0,0,0,0,0,1,1,0,0,0, 2'b10, 2'b00, 0);
    e_mult = mk(1,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 0);
    e_mflo = mk(1,0,0,0,0,0,0,1,0,0,0, 2'b10, 2'b00, 0);
    e_bne  = mk(0,1,1,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 0);
    e_beq  = mk(0,1,0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 0);
    e_j    = mk(0,0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 0);

    reset = 1'b1; enable = 1'b1; branch_taken = 1'b0;
    id_op = '0; id_funct = '0; id_rs = '0; id_rt = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tests++;
    assert (obs === e_bub && ex_rt === 5'd0 && illegal === 1'b0 && md_busy === 1'b0) else begin
      fails++;
      $error("FAIL reset_state: got ctl=%b rt=%0d ill=%b busy=%b want all zero", obs, ex_rt, illegal, md_busy);
    end

    // load-use on rs
    step("lw_r8",     6'b100011, 6'd0,      5'd1, 5'd8, 0, 1, 3'b110, e_lw,   5'd8, 0, 0);
    step("add_stall", 6'b000000, 6'b100000, 5'd8, 5'd8, 0, 1, 3'b000, e_bub,  5'd0, 0, 0);
    step("add_go",    6'b000000, 6'b100000, 5'd8, 5'd8, 0, 1, 3'b110, e_add,  5'd8, 0, 0);
    // rt = 0 and rt-not-a-source cases
    step("lw_r0",     6'b100011, 6'd0,      5'd1, 5'd0, 0, 1, 3'b110, e_lw,   5'd0, 0, 0);
    step("add_r0",    6'b000000, 6'b100000, 5'd0, 5'd0, 0, 1, 3'b110, e_add,  5'd0, 0, 0);
    step("lw_r8b",    6'b100011, 6'd0,      5'd1, 5'd8, 0, 1, 3'b110, e_lw,   5'd8, 0, 0);
    step("addi_r8",   6'b001000, 6'd0,      5'd1, 5'd8, 0, 1, 3'b110, e_addi, 5'd8, 0, 0);
    // MULT then MFLO: busy 4 cycles, 3 stall cycles
    step("mult",      6'b000000, 6'b011000, 5'd2, 5'd3, 0, 1, 3'b110, e_mult, 5'd3, 0, 1);
    step("mflo_s1",   6'b000000, 6'b010010, 5'd0, 5'd0, 0, 1, 3'b000, e_bub,  5'd0, 0, 1);
    step("mflo_s2",   6'b000000, 6'b010010, 5'd0, 5'd0, 0, 1, 3'b000, e_bub,  5'd0, 0, 1);
    step("mflo_s3",   6'b000000, 6'b010010, 5'd0, 5'd0, 0, 1, 3'b000, e_bub,  5'd0, 0, 1);
    step("mflo_go",   6'b000000, 6'b010010, 5'd0, 5'd0, 0, 1, 3'b110, e_mflo, 5'd0, 0, 0);
    // unrelated op after MULT does not stall
    step("mult2",     6'b000000, 6'b011000, 5'd2, 5'd3, 0, 1, 3'b110, e_mult, 5'd3, 0, 1);
    step("add_free",  6'b000000, 6'b100000, 5'd8, 5'd8, 0, 1, 3'b110, e_add,  5'd8, 0, 1);
    step("nop1",      6'b000000, 6'b000000, 5'd0, 5'd0, 0, 1, 3'b110, e_sll,  5'd0, 0, 1);
    step("nop2",      6'b000000, 6'b000000, 5'd0, 5'd0, 0, 1, 3'b110, e_sll,  5'd0, 0, 1);
    step("nop3",      6'b000000, 6'b000000, 5'd0, 5'd0, 0, 1, 3'b110, e_sll,  5'd0, 0, 0);
    // taken BNE beats a pending MD hazard; counter keeps running through the flush
    step("mult3",     6'b000000, 6'b011000, 5'd2, 5'd3, 0, 1, 3'b110, e_mult, 5'd3, 0, 1);
    step("bne",       6'b000101, 6'd0,      5'd4, 5'd5, 0, 1, 3'b110, e_bne,  5'd5, 0, 1);
    step("bne_taken", 6'b000000, 6'b010010, 5'd0, 5'd0, 1, 1, 3'b111, e_bub,  5'd0, 0, 1);
    step("mflo_s4",   6'b000000, 6'b010010, 5'd0, 5'd0, 0, 1, 3'b000, e_bub,  5'd0, 0, 1);
    step("mflo_go2",  6'b000000, 6'b010010, 5'd0, 5'd0, 0, 1, 3'b110, e_mflo, 5'd0, 0, 0);
    // taken branch beats load-use
    step("lw_r8c",    6'b100011, 6'd0,      5'd1, 5'd8, 0, 1, 3'b110, e_lw,   5'd8, 0, 0);
    step("flush_lu",  6'b000000, 6'b100000, 5'd8, 5'd8, 1, 1, 3'b111, e_bub,  5'd0, 0, 0);
    // jumps
    step("j",         6'b000010, 6'd0,      5'd0, 5'd0, 0, 1, 3'b111, e_j,    5'd0, 0, 0);
    step("beq",       6'b000100, 6'd0,      5'd1, 5'd2, 0, 1, 3'b110, e_beq,  5'd2, 0, 0);
    step("j_killed",  6'b000010, 6'd0,      5'd0, 5'd0, 1, 1, 3'b111, e_bub,  5'd0, 0, 0);
    // illegal opcode: bubble, one-cycle pulse
    step("illegal",   6'b111111, 6'd0,      5'd3, 5'd4, 0, 1, 3'b110, e_bub,  5'd0, 1, 0);
    step("after_ill", 6'b000000, 6'b000000, 5'd0, 5'd0, 0, 1, 3'b110, e_sll,  5'd0, 0, 0);
    // enable low freezes fetch
    step("disabled",  6'b000000, 6'b100000, 5'd1, 5'd2, 0, 0, 3'b000, e_bub,  5'd0, 0, 0);
    // store uses rt: load-use on rt
    step("lw_r8d",    6'b100011, 6'd0,      5'd1, 5'd8, 0, 1, 3'b110, e_lw,   5'd8, 0, 0);
    step("sw_stall",  6'b101011, 6'd0,      5'd1, 5'd8, 0, 1, 3'b000, e_bub,  5'd0, 0, 0);
    step("sw_go",     6'b101011, 6'd0,      5'd1, 5'd8, 0, 1, 3'b110, e_sw,   5'd8, 0, 0);
    // reset during MD countdown
    step("mult4",     6'b000000, 6'b011000, 5'd2, 5'd3, 0, 1, 3'b110, e_mult, 5'd3, 0, 1);
    step("nop4",      6'b000000, 6'b000000, 5'd0, 5'd0, 0, 1, 3'b110, e_sll,  5'd0, 0, 1);
    reset = 1'b1;
    step("reset_md",  6'b000000, 6'b100000, 5'd1, 5'd2, 0, 1, 3'b110, e_bub,  5'd0, 0, 0);
    reset = 1'b0;
    step("mflo_free", 6'b000000, 6'b010010, 5'd0, 5'd0, 0, 1, 3'b110, e_mflo, 5'd0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
